// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state encoding and counter sizing for serial_add_ctrl
package serial_add_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int clog2_min1(input int v);
    for (int r = 1; r < 31; r++) if ((1 << r) >= v) return r;
    return 31;
  endfunction
endpackage

// File: rtl/cla.sv
// cla: N-bit carry-lookahead slice
//   a, b : N-bit addends    cin  : carry-in
//   sum  : N-bit sum        cout : carry-out
module cla #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic         c;
  assign g = a & b;
  assign p = a ^ b;
  always_comb begin
    sum = '0;
    c = cin;
    for (int i = 0; i < N; i++) begin
      sum[i] = p[i] ^ c;
      c = g[i] | (p[i] & c);
    end
    cout = c;
  end
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: W=N*K-bit adder that reuses one N-bit cla slice over K cycles
//   clk, rst (async, active-high)
//   in_valid/in_ready, in_a, in_b, in_cin : operand handshake
//   out_valid/out_ready, out_y, out_cout  : result handshake (all outputs registered)
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int N = 32,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*K-1:0] in_a,
  input  logic [N*K-1:0] in_b,
  input  logic           in_cin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*K-1:0] out_y,
  output logic           out_cout
);
  localparam int W  = N * K;
  localparam int CW = clog2_min1(K);
  state_t        state;
  state_t        next;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  y_sh;
  logic          carry;
  logic [CW-1:0] cnt;
  logic [N-1:0]  slice_sum;
  logic          slice_cout;
  logic          last;
  cla #(.N(N)) u_cla (
    .a   (a_sh[N-1:0]),
    .b   (b_sh[N-1:0]),
    .cin (carry),
    .sum (slice_sum),
    .cout(slice_cout)
  );
  assign last = cnt == CW'(K - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    next = (state == IDLE) ? (in_valid ? RUN : IDLE) :
           (state == RUN)  ? (last ? DONE : RUN) :
           (state == DONE) ? (out_ready ? IDLE : DONE) : IDLE;
  end
  // Result slices enter at the top and migrate down, so after K shifts the
  // first (least-significant) slice sits at y_sh[N-1:0]; the concat-and-shift
  // form also stays legal when K=1.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      y_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (state == IDLE && in_valid) begin
      a_sh  <= in_a;
      b_sh  <= in_b;
      carry <= in_cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> N;
      b_sh  <= b_sh >> N;
      y_sh  <= W'({slice_sum, y_sh} >> N);
      carry <= slice_cout;
      cnt   <= cnt + 1'b1;
    end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign out_y     = y_sh;
  assign out_cout  = carry;
endmodule
